seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 4-digit common-segment 7-segment display on the board. It accepts a 16-bit hex value and a dot mask over a valid/ready handshake and double-buffers them so digits only change at frame boundaries. It then walks the four digit enables MSD-first with a blanking guard between digits, and drives the shared segment lines. It replaces the free-running counter/slice glue in `top` and sits between any value producer and the display pins.

---
 rtl/seg_pkg.sv | 49 ++++
 rtl/seg_decode.sv | 15 +
 rtl/seg_scan_ctrl.sv | 169 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan controller.
// Contents: digit count, segment pattern table (g..a, active-low),
// off/blank patterns, slot FSM state, and the buffered display word.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned VALUE_W    = NUM_DIGITS * NIB_W;
  localparam int unsigned SEG_W      = 8;

  localparam logic [SEG_W-1:0] SEG_OFF    = 8'hFF;
  localparam logic [6:0]       SEG_BLANK7 = 7'h7F;

  // Active-low g,f,e,d,c,b,a patterns; entry n is SEG_TABLE[n]
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } slot_state_e;

  // One buffered display word: four hex nibbles plus per-digit dots
  typedef struct packed {
    logic [VALUE_W-1:0]    value;
    logic [NUM_DIGITS-1:0] dots;
  } disp_word_t;

  function automatic logic [NUM_DIGITS-1:0] onehot_digit(input logic [1:0] slot);
    return NUM_DIGITS'(1) << slot;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational hex nibble to active-low 7-segment pattern with dot.
// Ports: nibble_i (hex digit), dot_i (1 = dot lit), blank_i (1 = segments
// g..a off, dot still honoured), pattern_c (active-low {dot,g..a}).
module seg_decode
  import seg_pkg::*;
(
  input  logic [NIB_W-1:0] nibble_i,
  input  logic             dot_i,
  input  logic             blank_i,
  output logic [SEG_W-1:0] pattern_c
);

  assign pattern_c = {~dot_i, (blank_i ? SEG_BLANK7 : SEG_TABLE[nibble_i])};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-segment display.
// Accepts a value/dots word over valid/ready into a one-deep pending buffer,
// promotes it to the display register at frame boundaries, and scans the
// digits MSD-first with a blanking guard at the start of every slot.
// Ports: CLK, RST_N (sync, active-low); in_value/in_dots/in_valid/in_ready
// producer handshake; blank_lz leading-zero suppression level; seg_n
// active-low segments; dig_en one-hot digit enable; frame_start pulse.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 4096,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [VALUE_W-1:0]    in_value,
  input  logic [NUM_DIGITS-1:0] in_dots,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  blank_lz,
  output logic [SEG_W-1:0]      seg_n,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_start
);

  localparam int unsigned CNT_W = $clog2(DIGIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYCLES);
  localparam logic [1:0]       SLOT_MSD = 2'(NUM_DIGITS - 1);

  logic                  run_q;
  logic [1:0]            slot_q, slot_d;
  logic [CNT_W-1:0]      count_q, count_d;
  slot_state_e           state_q, state_d;
  disp_word_t            pend_q, pend_d;
  logic                  pend_full_q, pend_full_d;
  disp_word_t            disp_q, disp_d;
  logic [SEG_W-1:0]      seg_n_q, seg_n_d;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
  logic                  frame_start_q, frame_start_d;
  logic                  in_ready_q, in_ready_d;

  logic                  boundary;
  logic                  accept;
  logic [NUM_DIGITS-1:0] lead_zero;
  logic [NIB_W-1:0]      dec_nibble;
  logic                  dec_dot;
  logic                  dec_blank;
  logic [SEG_W-1:0]      dec_pattern;

  assign in_ready    = in_ready_q;
  assign seg_n       = seg_n_q;
  assign dig_en      = dig_en_q;
  assign frame_start = frame_start_q;

  // The cycle holding count 0 of slot 3 is the frame boundary; its
  // closing edge promotes pending, so a same-cycle handshake sees in_ready=0.
  assign boundary = run_q && (slot_q == SLOT_MSD) && (count_q == '0);
  assign accept   = in_valid && in_ready_q;

  // Slot counter; first cycle out of reset parks on count 0 of slot 3
  always_comb begin
    slot_d  = slot_q;
    count_d = count_q;
    if (!run_q) begin
      slot_d  = SLOT_MSD;
      count_d = '0;
    end else if (count_q == CNT_LAST) begin
      count_d = '0;
      slot_d  = slot_q - 2'd1;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Pending/display double buffer
  always_comb begin
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    disp_d      = disp_q;
    if (boundary && pend_full_q) begin
      disp_d      = pend_q;
      pend_full_d = 1'b0;
    end else if (accept) begin
      pend_d.value = in_value;
      pend_d.dots  = in_dots;
      pend_full_d  = 1'b1;
    end
  end

  // Slot FSM next state: BLANK at the start of each slot, SHOW after the guard
  always_comb begin
    state_d = state_q;
    if (count_d == CNT_SHOW) begin
      state_d = SHOW;
    end else if (count_d == '0) begin
      state_d = BLANK;
    end
  end

  // Digit i is a leading zero when it and every higher nibble are zero
  always_comb begin
    lead_zero    = '0;
    lead_zero[3] = (disp_d.value[15:12] == '0);
    lead_zero[2] = lead_zero[3] && (disp_d.value[11:8] == '0);
    lead_zero[1] = lead_zero[2] && (disp_d.value[7:4] == '0);
  end

  // Single decoder fed by a 4:1 nibble mux on the upcoming slot
  always_comb begin
    dec_nibble = disp_d.value[3:0];
    case (slot_d)
      2'd3:    dec_nibble = disp_d.value[15:12];
      2'd2:    dec_nibble = disp_d.value[11:8];
      2'd1:    dec_nibble = disp_d.value[7:4];
      default: dec_nibble = disp_d.value[3:0];
    endcase
    dec_dot   = disp_d.dots[slot_d];
    dec_blank = blank_lz && lead_zero[slot_d];
  end

  seg_decode u_decode (
    .nibble_i  (dec_nibble),
    .dot_i     (dec_dot),
    .blank_i   (dec_blank),
    .pattern_c (dec_pattern)
  );

  // Outputs are computed from next state so dig_en and seg_n move together
  always_comb begin
    seg_n_d       = SEG_OFF;
    dig_en_d      = '0;
    frame_start_d = (slot_d == SLOT_MSD) && (count_d == '0);
    in_ready_d    = ~pend_full_d;
    if (state_d == SHOW) begin
      seg_n_d  = dec_pattern;
      dig_en_d = onehot_digit(slot_d);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      run_q         <= 1'b0;
      slot_q        <= SLOT_MSD;
      count_q       <= '0;
      state_q       <= BLANK;
      pend_q        <= '0;
      pend_full_q   <= 1'b0;
      disp_q        <= '0;
      seg_n_q       <= SEG_OFF;
      dig_en_q      <= '0;
      frame_start_q <= 1'b0;
      in_ready_q    <= 1'b0;
    end else begin
      run_q         <= 1'b1;
      slot_q        <= slot_d;
      count_q       <= count_d;
      state_q       <= state_d;
      pend_q        <= pend_d;
      pend_full_q   <= pend_full_d;
      disp_q        <= disp_d;
      seg_n_q       <= seg_n_d;
      dig_en_q      <= dig_en_d;
      frame_start_q <= frame_start_d;
      in_ready_q    <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with a frame-level reference model.
module tb_seg_scan_ctrl;

  localparam int DC = 8;
  localparam int BC = 2;
  localparam int FRAME = 4 * DC;

  logic        CLK;
  logic        RST_N;
  logic [15:0] in_value;
  logic [3:0]  in_dots;
  logic        in_valid;
  logic        in_ready;
  logic        blank_lz;
  logic [7:0]  seg_n;
  logic [3:0]  dig_en;
  logic        frame_start;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: cycles since reset release, buffers, sampled blank_lz
  int          m_t = -1;
  logic        m_full = 1'b0;
  logic [15:0] m_pend = '0;
  logic [3:0]  m_pdots = '0;
  logic [15:0] m_disp = '0;
  logic [3:0]  m_ddots = '0;
  logic        m_blz = 1'b0;
  logic        m_acc = 1'b0;

  seg_scan_ctrl #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .in_value    (in_value),
    .in_dots     (in_dots),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .blank_lz    (blank_lz),
    .seg_n       (seg_n),
    .dig_en      (dig_en),
    .frame_start (frame_start)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Expected {frame_start, in_ready, dig_en, seg_n} for the current cycle
  function automatic logic [13:0] exp_out();
    int slot, cnt;
    logic [3:0] dig;
    logic [7:0] seg;
    logic [15:0] upper;
    if (m_t < 0) return {1'b0, 1'b0, 4'h0, 8'hFF};
    slot = 3 - ((m_t / DC) % 4);
    cnt  = m_t % DC;
    dig  = 4'h0;
    seg  = 8'hFF;
    if (cnt >= BC) begin
      dig    = 4'(1 << slot);
      upper  = m_disp >> (4 * slot);
      seg[7] = ~m_ddots[slot];
      seg[6:0] = (m_blz && slot > 0 && upper == 16'h0) ? 7'h7F : seg7(upper[3:0]);
    end
    return {(m_t % FRAME) == 0, !m_full, dig, seg};
  endfunction

  // One clock: capture pre-edge inputs, advance model, settle past the edge
  task automatic step();
    logic rst_s, blz_s, acc;
    logic [15:0] v;
    logic [3:0] d;
    rst_s = RST_N;
    blz_s = blank_lz;
    acc   = in_valid && (m_t >= 0) && !m_full;
    v     = in_value;
    d     = in_dots;
    @(posedge CLK);
    if (!rst_s) begin
      m_t = -1; m_full = 1'b0; m_disp = '0; m_ddots = '0;
      acc = 1'b0;
    end else begin
      if (m_t >= 0 && (m_t % FRAME) == 0 && m_full) begin
        m_disp = m_pend; m_ddots = m_pdots; m_full = 1'b0;
      end else if (acc) begin
        m_pend = v; m_pdots = d; m_full = 1'b1;
      end
      m_t++;
    end
    m_blz = blz_s;
    m_acc = acc;
    #1;
  endtask

  task automatic test_reset();
    logic [13:0] e;
    RST_N = 1'b0; in_valid = 1'b0; in_value = '0; in_dots = '0; blank_lz = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      e = exp_out();
      n_cmp++;
      if ({frame_start, in_ready, dig_en, seg_n} !== e) begin
        n_err++;
        $display("FAIL reset i=%0d got %h exp %h", i, {frame_start, in_ready, dig_en, seg_n}, e);
      end
    end
    n_cmp++;
    if (seg_n !== 8'hFF || dig_en !== 4'h0 || frame_start !== 1'b0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_const got seg=%h dig=%h fs=%b rdy=%b exp FF 0 0 0", seg_n, dig_en, frame_start, in_ready);
    end
    RST_N = 1'b1;
  endtask

  task automatic test_idle_scan();
    logic [13:0] e;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      step();
      e = exp_out();
      n_cmp++;
      if ({frame_start, in_ready, dig_en, seg_n} !== e) begin
        n_err++;
        $display("FAIL idle t=%0d got %h exp %h", m_t, {frame_start, in_ready, dig_en, seg_n}, e);
      end
      if ((m_t % DC) >= BC) begin
        n_cmp++;
        if (seg_n !== 8'hC0) begin
          n_err++;
          $display("FAIL idle_zero t=%0d got seg=%h exp C0", m_t, seg_n);
        end
      end
    end
  endtask

  task automatic test_write_mid();
    logic [13:0] e;
    while ((m_t % FRAME) != 10) step();
    in_value = 16'h12AF; in_dots = 4'b0010; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL write_ready_drop got %b exp 0", in_ready);
    end
    for (int i = 0; i < 2 * FRAME + 8; i++) begin
      step();
      e = exp_out();
      n_cmp++;
      if ({frame_start, in_ready, dig_en, seg_n} !== e) begin
        n_err++;
        $display("FAIL write_mid t=%0d got %h exp %h", m_t, {frame_start, in_ready, dig_en, seg_n}, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] e;
    int stage;
    stage = 0;
    in_value = 16'h1111; in_dots = 4'h0; in_valid = 1'b1;
    for (int i = 0; i < 4 * FRAME; i++) begin
      step();
      if (m_acc && stage == 0) begin
        stage = 1; in_value = 16'h2222; in_dots = 4'h5;
      end else if (m_acc && stage == 1) begin
        stage = 2; in_valid = 1'b0;
      end
      e = exp_out();
      n_cmp++;
      if ({frame_start, in_ready, dig_en, seg_n} !== e) begin
        n_err++;
        $display("FAIL b2b t=%0d got %h exp %h", m_t, {frame_start, in_ready, dig_en, seg_n}, e);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_boundary_hs();
    logic [13:0] e;
    while ((m_t % FRAME) != 0) step();
    in_value = 16'hBEEF; in_dots = 4'b1001; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      e = exp_out();
      n_cmp++;
      if ({frame_start, in_ready, dig_en, seg_n} !== e) begin
        n_err++;
        $display("FAIL boundary_hs t=%0d got %h exp %h", m_t, {frame_start, in_ready, dig_en, seg_n}, e);
      end
      step();
    end
  endtask

  task automatic test_lz();
    logic [13:0] e;
    logic [15:0] vals [2];
    vals[0] = 16'h0030;
    vals[1] = 16'h0000;
    blank_lz = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_value = vals[k]; in_dots = 4'h0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 2 * FRAME + 4; i++) begin
        step();
        e = exp_out();
        n_cmp++;
        if ({frame_start, in_ready, dig_en, seg_n} !== e) begin
          n_err++;
          $display("FAIL lz v=%h t=%0d got %h exp %h", vals[k], m_t, {frame_start, in_ready, dig_en, seg_n}, e);
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_random();
    logic [13:0] e;
    for (int i = 0; i < 800; i++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      in_value = 16'($urandom);
      in_dots  = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 3) == 0) in_value[15:8] = 8'h00;
      step();
      e = exp_out();
      n_cmp++;
      if ({frame_start, in_ready, dig_en, seg_n} !== e) begin
        n_err++;
        $display("FAIL random t=%0d got %h exp %h", m_t, {frame_start, in_ready, dig_en, seg_n}, e);
      end
    end
    in_valid = 1'b0;
    blank_lz = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [13:0] e;
    while ((m_t % FRAME) != 3 || m_full) step();
    in_value = 16'h5A5A; in_dots = 4'hF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    while ((m_t % FRAME) != 20) step();
    RST_N = 1'b0;
    step();
    n_cmp++;
    if (dig_en !== 4'h0 || seg_n !== 8'hFF) begin
      n_err++;
      $display("FAIL reset_mid got dig=%h seg=%h exp 0 FF", dig_en, seg_n);
    end
    RST_N = 1'b1;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      step();
      e = exp_out();
      n_cmp++;
      if ({frame_start, in_ready, dig_en, seg_n} !== e) begin
        n_err++;
        $display("FAIL reset_mid_after t=%0d got %h exp %h", m_t, {frame_start, in_ready, dig_en, seg_n}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_write_mid();
    test_back_to_back();
    test_boundary_hs();
    test_lz();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
